axis_array_mult_pipe: RTL and testbench

Parametrised, AXI-Stream pipelined array multiplier; successor to the fixed 8-bit, 3-stage array multiplier in the DSP accelerator datapath. Computes a WIDTH×WIDTH product through a registered partial-product stage and a registered balanced adder tree. Adds full valid/ready backpressure, TLAST pass-through, optional signed mode and zero-operand gating. Sits between the AXI-Stream input FIFO and the FFT/accumulate stages.

---
 rtl/axis_array_mult_pipe_if.sv | 31 +++
 rtl/axis_array_mult_pipe.sv | 93 +++++++++
 tb/tb_axis_array_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_array_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_array_mult_pipe_if
// Brief    : AXI-Stream in/out bundle for axis_array_mult_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_array_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 s_tvalid;
  logic                 s_tready;
  logic [2*WIDTH-1:0]   s_tdata;
  logic                 s_tuser;
  logic                 s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [2*WIDTH-1:0]   m_tdata;
  logic                 m_tlast;

  // slave: the multiplier's view; master: the surrounding stream environment
  modport slave (
    input  s_tvalid, s_tdata, s_tuser, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output s_tvalid, s_tdata, s_tuser, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface
`default_nettype wire

// File: rtl/axis_array_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : axis_array_mult_pipe
// Brief    : Pipelined WIDTHxWIDTH array multiplier with AXI-Stream handshake,
//            zero-operand gating; signed mode when ARRMUL_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module axis_array_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  axis_array_mult_pipe_if.slave bus
);

  localparam int c_PW    = 2 * WIDTH;
  localparam int c_NODES = 2 * WIDTH - 1;
  localparam int c_ROOT  = 2 * WIDTH - 2;

  // Node array: leaves 0..WIDTH-1 are stage-0 partial products, followed by
  // each adder level in turn; level l starts at c_PW - (c_PW >> l).
  logic [c_PW-1:0]  r_node     [c_NODES];
  logic [c_PW-1:0]  w_node_nxt [c_NODES];
  logic [LEVELS:0]  r_vld;
  logic [LEVELS:0]  r_last;
  logic [LEVELS-1:0] r_zero;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [c_PW-1:0]  w_a_ext;
  logic [c_PW-1:0]  w_row;
  logic             w_zero;
  logic             w_adv;

  assign w_a    = bus.s_tdata[WIDTH-1:0];
  assign w_b    = bus.s_tdata[c_PW-1:WIDTH];
  assign w_zero = (w_a == '0) || (w_b == '0);
  assign w_adv  = !r_vld[LEVELS] || bus.m_tready;

`ifdef ARRMUL_SIGNED_EN
  logic w_sgn;
  assign w_sgn   = bus.s_tuser;
  assign w_a_ext = w_sgn ? {{WIDTH{w_a[WIDTH-1]}}, w_a} : {{WIDTH{1'b0}}, w_a};
`else
  assign w_a_ext = {{WIDTH{1'b0}}, w_a};
`endif

  always_comb begin
    w_node_nxt = r_node;
    w_row      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_row = w_b[i] ? (w_a_ext << i) : '0;
`ifdef ARRMUL_SIGNED_EN
      // The sign bit of b carries weight -2^(WIDTH-1), so its row is negated
      if (w_sgn && (i == WIDTH - 1)) begin
        w_row = -w_row;
      end
`endif
      if (!w_zero) begin
        w_node_nxt[i] = w_row;
      end
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < (WIDTH >> l); j++) begin
        w_node_nxt[c_PW - (c_PW >> l) + j] =
          r_zero[l-1] ? '0 :
          r_node[c_PW - (c_PW >> (l-1)) + 2*j] + r_node[c_PW - (c_PW >> (l-1)) + 2*j + 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_node <= '{default: '0};
      r_vld  <= '0;
      r_last <= '0;
      r_zero <= '0;
    end else if (w_adv) begin
      r_node <= w_node_nxt;
      r_vld  <= {r_vld[LEVELS-1:0], bus.s_tvalid};
      r_last <= {r_last[LEVELS-1:0], bus.s_tvalid && bus.s_tlast};
      r_zero <= {r_zero[LEVELS-2:0], w_zero};
    end
  end

  assign bus.s_tready = w_adv;
  assign bus.m_tvalid = r_vld[LEVELS];
  assign bus.m_tdata  = r_node[c_ROOT];
  assign bus.m_tlast  = r_last[LEVELS];

endmodule
`default_nettype wire

// File: tb/tb_axis_array_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_array_mult_pipe
// Brief    : Scoreboard bench for axis_array_mult_pipe (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_array_mult_pipe;

  localparam int c_W   = 8;
  localparam int c_LAT = 1 + $clog2(c_W);

  typedef struct {
    logic [2*c_W-1:0] d;
    logic             l;
    int               cyc;
    logic             lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   rdy_mode;
  int   pcnt;
  logic lat_chk;
  exp_t sbq[$];

  logic             hold_pend;
  logic [2*c_W-1:0] hold_d;
  logic             hold_l;

  axis_array_mult_pipe_if #(.WIDTH(c_W)) bus ();

  axis_array_mult_pipe #(.WIDTH(c_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer product, signed only when the feature is built in
  function automatic logic [2*c_W-1:0] model(input logic [c_W-1:0] a,
                                             input logic [c_W-1:0] b,
                                             input logic u);
    logic        sg;
    int          sa;
    int          sb;
    logic [31:0] p;
    sg = u;
`ifndef ARRMUL_SIGNED_EN
    sg = 1'b0;
`endif
    sa = sg ? int'($signed(a)) : int'(a);
    sb = sg ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return p[2*c_W-1:0];
  endfunction

  // Downstream ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random
  initial begin
    pcnt = 0;
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pcnt++;
      case (rdy_mode)
        1:       bus.m_tready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
        2:       bus.m_tready = ($urandom_range(0, 2) != 0);
        default: bus.m_tready = 1'b1;
      endcase
    end
  end

  // Monitor: records accepted beats, checks outputs and handshake rules
  initial begin
    exp_t e;
    exp_t o;
    cyc = 0;
    hold_pend = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sbq.delete();
        hold_pend = 1'b0;
      end else begin
        chk("s_tready_rule", {31'd0, bus.s_tready}, {31'd0, !bus.m_tvalid || bus.m_tready});
        if (hold_pend) begin
          chk("hold_valid", {31'd0, bus.m_tvalid}, 32'd1);
          chk("hold_data", {16'd0, bus.m_tdata}, {16'd0, hold_d});
          chk("hold_last", {31'd0, bus.m_tlast}, {31'd0, hold_l});
        end
        if (bus.m_tvalid && bus.m_tready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none", bus.m_tdata);
          end else begin
            o = sbq.pop_front();
            chk("product", {16'd0, bus.m_tdata}, {16'd0, o.d});
            chk("tlast", {31'd0, bus.m_tlast}, {31'd0, o.l});
            if (o.lat) chk("latency", cyc - o.cyc, c_LAT);
          end
        end
        hold_pend = bus.m_tvalid && !bus.m_tready;
        hold_d    = bus.m_tdata;
        hold_l    = bus.m_tlast;
        if (bus.s_tvalid && bus.s_tready) begin
          e.d   = model(bus.s_tdata[c_W-1:0], bus.s_tdata[2*c_W-1:c_W], bus.s_tuser);
          e.l   = bus.s_tlast;
          e.cyc = cyc;
          e.lat = lat_chk;
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                      input logic u, input logic l);
    logic acc;
    int   n;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = {b, a};
    bus.s_tuser  = u;
    bus.s_tlast  = l;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got 0 expected 1");
    end
    bus.s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_tvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.s_tdata = 16'($urandom);
      bus.s_tlast = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    idle(6);
  endtask

  function automatic logic [c_W-1:0] rand_op();
    return ($urandom_range(0, 7) == 0) ? '0 : c_W'($urandom);
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rdy_mode = 0;
    lat_chk = 1'b0;
    rst_n = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata = '0;
    bus.s_tuser = 1'b0;
    bus.s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_m_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
    chk("rst_m_tdata", {16'd0, bus.m_tdata}, 32'd0);
    chk("rst_m_tlast", {31'd0, bus.m_tlast}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", {31'd0, bus.s_tready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed corner operands with latency tracking
    lat_chk = 1'b1;
    send(8'hFF, 8'hFF, 1'b0, 1'b0);
    drain();
    send(8'h80, 8'hFF, 1'b1, 1'b0);
    send(8'h80, 8'h7F, 1'b1, 1'b0);
    send(8'h80, 8'h7F, 1'b0, 1'b0);
    send(8'h03, 8'h05, 1'b0, 1'b0);
    send(8'h00, 8'hA5, 1'b0, 1'b0);
    send(8'hA5, 8'h00, 1'b1, 1'b0);
    drain();

    // TLAST on beat 3 of 4 with one bubble
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    idle(1);
    send(8'h55, 8'h66, 1'b0, 1'b1);
    send(8'h77, 8'h88, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Back-to-back random beats against the 1,0,0,1 ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) begin
      send(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
    end
    drain();

    // Random traffic with random bubbles and random ready
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    drain();

    // Reset with three beats in flight, then one clean beat
    send(8'h12, 8'h34, 1'b0, 1'b0);
    send(8'h56, 8'h78, 1'b0, 1'b1);
    send(8'h9A, 8'hBC, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
    chk("midrst_m_tdata", {16'd0, bus.m_tdata}, 32'd0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(8'h0F, 8'h0E, 1'b0, 1'b1);
    drain();
    lat_chk = 1'b0;

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
